// File: rtl/vector_instr_fanout.sv
// Replicates one instruction stream into per-slice FIFOs selected by a slice mask.
// Each slice drains through its own valid/ready channel, so a stalled slice only blocks once its FIFO is full.
module vector_instr_fanout #(
    parameter int SLICES = 16,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        t_instr_dat,
    input  logic [SLICES-1:0]        t_instr_mask,
    input  logic                     t_instr_valid,
    output logic                     t_instr_ready,
    output logic [SLICES*DATA_W-1:0] i_instr_dat,
    output logic [SLICES-1:0]        i_instr_valid,
    input  logic [SLICES-1:0]        i_instr_ready,
    input  logic                     flush,
    output logic                     idle,
    output logic [15:0]              drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

    logic [DATA_W-1:0] mem_q    [SLICES][DEPTH];
    logic [DATA_W-1:0] mem_d    [SLICES][DEPTH];
    logic [PW-1:0]     wr_ptr_q [SLICES];
    logic [PW-1:0]     wr_ptr_d [SLICES];
    logic [PW-1:0]     rd_ptr_q [SLICES];
    logic [PW-1:0]     rd_ptr_d [SLICES];
    logic [OW-1:0]     occ_q    [SLICES];
    logic [OW-1:0]     occ_d    [SLICES];
    logic [15:0]       drop_cnt_q;
    logic [15:0]       drop_cnt_d;

    logic [SLICES-1:0] full;
    logic [SLICES-1:0] push;
    logic [SLICES-1:0] pop;
    logic              accept;

    // Ready looks only at the mask and registered occupancy; a popping full FIFO still blocks.
    always_comb begin
        for (int s = 0; s < SLICES; s++) begin
            full[s] = (occ_q[s] == OCC_FULL);
        end
        t_instr_ready = !reset && !flush && ((t_instr_mask & full) == '0);
        accept        = t_instr_valid && t_instr_ready;
        push          = accept ? t_instr_mask : '0;
        pop           = i_instr_valid & i_instr_ready;
    end

    always_comb begin
        i_instr_dat = '0;
        for (int s = 0; s < SLICES; s++) begin
            i_instr_valid[s]               = (occ_q[s] != '0);
            i_instr_dat[s*DATA_W +: DATA_W] = mem_q[s][rd_ptr_q[s]];
        end
        idle     = (i_instr_valid == '0);
        drop_cnt = drop_cnt_q;
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        drop_cnt_d = drop_cnt_q;
        for (int s = 0; s < SLICES; s++) begin
            if (push[s]) begin
                mem_d[s][wr_ptr_q[s]] = t_instr_dat;
                wr_ptr_d[s]           = wr_ptr_q[s] + 1'b1;
            end
            if (pop[s]) begin
                rd_ptr_d[s] = rd_ptr_q[s] + 1'b1;
            end
            case ({push[s], pop[s]})
                2'b10:   occ_d[s] = occ_q[s] + 1'b1;
                2'b01:   occ_d[s] = occ_q[s] - 1'b1;
                default: occ_d[s] = occ_q[s];
            endcase
            // Flush only resets the bookkeeping; stale storage is never visible once occ is zero.
            if (flush) begin
                wr_ptr_d[s] = '0;
                rd_ptr_d[s] = '0;
                occ_d[s]    = '0;
            end
        end
        if (accept && (t_instr_mask == '0) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SLICES; s++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[s][e] <= '0;
                end
                wr_ptr_q[s] <= '0;
                rd_ptr_q[s] <= '0;
                occ_q[s]    <= '0;
            end
            drop_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SLICES; s++) begin
                assert (occ_q[s] <= OCC_FULL);
                assert (!(push[s] && full[s]));
                assert (!(pop[s] && (occ_q[s] == '0)));
            end
        end
    end

endmodule
